data_mem_lsu: RTL

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

---
 rtl/data_mem_lsu.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// Byte-addressed RV32I data memory with a load/store unit front end.
// One outstanding request; fixed latency of WAIT_CYCLES wait states before the response.
`timescale 1ns/1ps

module data_mem_lsu #(
  parameter int         ADDR_W      = 20,
  parameter int         WAIT_CYCLES = 1,
  parameter logic [7:0] INIT_BYTE   = 8'hF0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, next_state;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [2:0]        lat_funct3;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  // Contents start at INIT_BYTE and are never touched by reset.
  logic [7:0] mem [DEPTH] = '{default: INIT_BYTE};

  logic              accept, req_bad, req_illegal, req_misaligned;
  logic              use_req, entering_resp, err_now, commit;
  logic              cur_we;
  logic [2:0]        cur_funct3;
  logic [ADDR_W-1:0] cur_addr, addr1, addr2, addr3;
  logic [31:0]       cur_wdata, load_data;
  logic [7:0]        b0, b1, b2, b3;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                     (req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));
    req_misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                     ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    req_bad        = req_illegal || req_misaligned;
  end

  // With WAIT_CYCLES=0 the commit edge is the accept edge, so IDLE works on live inputs.
  assign use_req    = (state == IDLE);
  assign cur_we     = use_req ? req_we     : lat_we;
  assign cur_funct3 = use_req ? req_funct3 : lat_funct3;
  assign cur_addr   = use_req ? req_addr   : lat_addr;
  assign cur_wdata  = use_req ? req_wdata  : lat_wdata;
  assign err_now    = use_req && req_bad;

  assign addr1 = cur_addr + ADDR_W'(1);
  assign addr2 = cur_addr + ADDR_W'(2);
  assign addr3 = cur_addr + ADDR_W'(3);
  assign b0    = mem[cur_addr];
  assign b1    = mem[addr1];
  assign b2    = mem[addr2];
  assign b3    = mem[addr3];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_data = 32'h0;
    case (cur_funct3)
      F3_B:    load_data = {{24{b0[7]}}, b0};
      F3_H:    load_data = {{16{b1[7]}}, b1, b0};
      F3_W:    load_data = {b3, b2, b1, b0};
      F3_BU:   load_data = {24'h0, b0};
      F3_HU:   load_data = {16'h0, b1, b0};
      default: load_data = 32'h0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (req_bad || WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wait_cnt == LAST_WAIT) next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign entering_resp = (next_state == RESP) && (state != RESP);
  assign commit        = entering_resp && reset_n && cur_we && !err_now;

  // Outputs decoded from state.
  always_comb begin
    req_ready = (state == IDLE) && reset_n;
    rsp_valid = (state == RESP);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (entering_resp) begin
        rsp_err   <= err_now;
        rsp_rdata <= (err_now || cur_we) ? 32'h0 : load_data;
      end
    end
  end

  // NOTE: the request capture registers are pure datapath and need no reset; accept already excludes reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end
  end

  // Little-endian byte lanes: byte addr+k carries data bits [8k+7:8k].
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cur_addr] <= cur_wdata[7:0];
      if (cur_funct3 == F3_H || cur_funct3 == F3_W) mem[addr1] <= cur_wdata[15:8];
      if (cur_funct3 == F3_W) begin
        mem[addr2] <= cur_wdata[23:16];
        mem[addr3] <= cur_wdata[31:24];
      end
    end
  end

endmodule
